us_ping_responder: RTL and testbench



---
 rtl/us_pkg.sv | 29 ++
 rtl/us_sig_sync.sv | 35 +++
 rtl/us_ping_responder.sv | 166 ++++++++++++++++
 tb/tb_us_ping_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/us_pkg.sv
// Shared types and default timing for the ultrasonic ping responder and the
// navigation-side sensor readers.
package us_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    HOLDOFF = 3'd2,
    ECHO    = 3'd3,
    GAP     = 3'd4
  } us_state_e;

  localparam int unsigned TRIG_MIN_DEF   = 200;
  localparam int unsigned HOLDOFF_DEF    = 75000;
  localparam int unsigned CYC_PER_CM_DEF = 5800;
  localparam int unsigned GAP_DEF        = 20000;
  localparam int unsigned NO_OBJ_DEF     = 1850000;

  localparam logic [7:0] MIN_CM = 8'd2;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] clamp_cm(input logic [7:0] d);
    return (d < MIN_CM) ? MIN_CM : d;
  endfunction

endpackage

// File: rtl/us_sig_sync.sv
// Two-flop synchronizer for the shared trigger/echo line with registered
// rise/fall strobes that line up with the synchronized level change.
module us_sig_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sig_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
      fall_q <= ~s1_q & s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/us_ping_responder.sv
// PING-style ultrasonic sensor emulator: validates a host trigger, waits a
// hold-off, then drives an echo of DIST_LAT x CYC_PER_CM cycles on SIG.
// Build option US_NO_OBJECT_EN: DISTANCE = 255 yields a flat NO_OBJ_CYC echo.
module us_ping_responder
  import us_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_DEF,
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
  parameter int unsigned GAP_CYC      = GAP_DEF
`ifdef US_NO_OBJECT_EN
  ,
  parameter int unsigned NO_OBJ_CYC   = NO_OBJ_DEF
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire        SIG,
  input  logic [7:0] DISTANCE,
  output logic       BUSY,
  output logic       ECHO_ACTIVE,
  output logic [7:0] PING_COUNT
);

`ifdef US_NO_OBJECT_EN
  localparam int unsigned TMR_MAX = umax(umax(HOLDOFF_CYC, GAP_CYC), NO_OBJ_CYC);
`else
  localparam int unsigned TMR_MAX = umax(HOLDOFF_CYC, GAP_CYC);
`endif
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int SUB_W = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int TRG_W = $clog2(TRIG_MIN_CYC + 1);

  us_state_e         state_q;
  logic [TRG_W-1:0]  trg_cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [7:0]        cm_q;
  logic [SUB_W-1:0]  sub_q;
  logic [7:0]        dist_lat_q;
  logic [7:0]        ping_cnt_q;
  logic              busy_q;
  logic              oe_q;
`ifdef US_NO_OBJECT_EN
  logic              nobj_q;
`endif

  logic sig_sync;
  logic sig_rise;
  logic sig_fall;

  us_sig_sync u_sync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .sig_i  (SIG),
    .sync_o (sig_sync),
    .rise_o (sig_rise),
    .fall_o (sig_fall)
  );

  assign SIG         = oe_q ? 1'b1 : 1'bz;
  assign BUSY        = busy_q;
  assign ECHO_ACTIVE = oe_q;
  assign PING_COUNT  = ping_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      trg_cnt_q  <= '0;
      tmr_q      <= '0;
      cm_q       <= '0;
      sub_q      <= '0;
      dist_lat_q <= '0;
      ping_cnt_q <= '0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
`ifdef US_NO_OBJECT_EN
      nobj_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          trg_cnt_q <= '0;
          if (sig_rise) begin
            // the cycle carrying the rise strobe is already high time
            state_q   <= TRIG;
            trg_cnt_q <= TRG_W'(1);
          end
        end

        TRIG: begin
          if (sig_fall) begin
            if (trg_cnt_q >= TRG_W'(TRIG_MIN_CYC)) begin
              state_q    <= HOLDOFF;
              busy_q     <= 1'b1;
              tmr_q      <= TMR_W'(HOLDOFF_CYC - 1);
              dist_lat_q <= clamp_cm(DISTANCE);
              ping_cnt_q <= ping_cnt_q + 8'd1;
            end else begin
              state_q <= IDLE;
            end
          end else if (sig_sync && (trg_cnt_q < TRG_W'(TRIG_MIN_CYC))) begin
            trg_cnt_q <= trg_cnt_q + TRG_W'(1);
          end
        end

        HOLDOFF: begin
          if (tmr_q == '0) begin
            state_q <= ECHO;
            oe_q    <= 1'b1;
            cm_q    <= dist_lat_q;
            sub_q   <= SUB_W'(CYC_PER_CM - 1);
`ifdef US_NO_OBJECT_EN
            nobj_q  <= (dist_lat_q == 8'hFF);
            tmr_q   <= TMR_W'(NO_OBJ_CYC - 1);
`endif
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        ECHO: begin
`ifdef US_NO_OBJECT_EN
          if (nobj_q) begin
            if (tmr_q == '0) begin
              state_q <= GAP;
              oe_q    <= 1'b0;
              nobj_q  <= 1'b0;
              tmr_q   <= TMR_W'(GAP_CYC - 1);
            end else begin
              tmr_q <= tmr_q - TMR_W'(1);
            end
          end else
`endif
          if (sub_q == '0) begin
            if (cm_q == 8'd1) begin
              state_q <= GAP;
              oe_q    <= 1'b0;
              tmr_q   <= TMR_W'(GAP_CYC - 1);
            end else begin
              cm_q  <= cm_q - 8'd1;
              sub_q <= SUB_W'(CYC_PER_CM - 1);
            end
          end else begin
            sub_q <= sub_q - SUB_W'(1);
          end
        end

        GAP: begin
          if (tmr_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_us_ping_responder.sv
// Directed bench for us_ping_responder using scaled-down timing parameters.
module tb_us_ping_responder;

  localparam int TRIG_MIN = 20;
  localparam int HOLDOFF  = 100;
  localparam int CPC      = 10;
  localparam int GAPC     = 50;
`ifdef US_NO_OBJECT_EN
  localparam int NOOBJ    = 3000;
  localparam int EXP_255  = NOOBJ;
`else
  localparam int EXP_255  = 255 * CPC;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DISTANCE = 8'd0;
  logic       BUSY;
  logic       ECHO_ACTIVE;
  logic [7:0] PING_COUNT;
  logic       host_oe = 1'b0;
  wire        sig_w;

  assign sig_w = host_oe ? 1'b1 : 1'bz;
  pulldown (sig_w);

  us_ping_responder #(
    .TRIG_MIN_CYC (TRIG_MIN),
    .HOLDOFF_CYC  (HOLDOFF),
    .CYC_PER_CM   (CPC),
    .GAP_CYC      (GAPC)
`ifdef US_NO_OBJECT_EN
    ,
    .NO_OBJ_CYC   (NOOBJ)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SIG         (sig_w),
    .DISTANCE    (DISTANCE),
    .BUSY        (BUSY),
    .ECHO_ACTIVE (ECHO_ACTIVE),
    .PING_COUNT  (PING_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int cyc = 0;
  int busy_rise_cyc = 0, busy_fall_cyc = 0, er_cyc = 0, ef_cyc = 0;
  int busy_rises = 0, echo_rises = 0, sig_bad = 0;
  int rel_cyc = 0;
  logic busy_p = 1'b0, echo_p = 1'b0;

  // Event log, sampled 1 time unit after each rising edge
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (BUSY && !busy_p) begin busy_rise_cyc = cyc; busy_rises++; end
    if (!BUSY && busy_p) busy_fall_cyc = cyc;
    if (ECHO_ACTIVE && !echo_p) begin er_cyc = cyc; echo_rises++; end
    if (!ECHO_ACTIVE && echo_p) ef_cyc = cyc;
    if (!host_oe && (sig_w !== ECHO_ACTIVE)) sig_bad++;
    busy_p = BUSY;
    echo_p = ECHO_ACTIVE;
  end

  task automatic trigger(input int d, input int len);
    DISTANCE = 8'(d);
    @(negedge CLK);
    host_oe = 1'b1;
    repeat (len) @(negedge CLK);
    host_oe = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if ((busy_fall_cyc > rel_cyc) && !BUSY) begin ok = 1'b1; break; end
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_ping(input string tag, input int width);
    chk({tag, "_lat"},   32'(busy_rise_cyc - rel_cyc), 32'd3);
    chk({tag, "_hold"},  32'(er_cyc - busy_rise_cyc),  32'(HOLDOFF));
    chk({tag, "_width"}, 32'(ef_cyc - er_cyc),         32'(width));
    chk({tag, "_gap"},   32'(busy_fall_cyc - ef_cyc),  32'(GAPC));
  endtask

  int base_b, base_e;

  initial begin
    repeat (4) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_echo", 32'(ECHO_ACTIVE), 32'd0);
    chk("rst_cnt",  32'(PING_COUNT), 32'd0);
    chk("rst_sig",  32'(sig_w), 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // nominal ping, long trigger
    trigger(100, 50);
    wait_done("d100", 2000);
    chk_ping("d100", 100 * CPC);
    chk("d100_cnt", 32'(PING_COUNT), 32'd1);

    // short triggers rejected, including one cycle under the minimum
    base_b = busy_rises;
    trigger(3, TRIG_MIN - 1);
    repeat (40) @(negedge CLK);
    trigger(3, 5);
    repeat (40) @(negedge CLK);
    chk("short_busy", 32'(busy_rises - base_b), 32'd0);
    chk("short_cnt",  32'(PING_COUNT), 32'd1);

    // minimum trigger, DISTANCE 0 clamps to 2 cm; change during HOLDOFF ignored
    trigger(0, TRIG_MIN);
    repeat (10) @(negedge CLK);
    chk("clamp_inhold", 32'(BUSY), 32'd1);
    DISTANCE = 8'd50;
    wait_done("clamp", 1000);
    chk_ping("clamp", 2 * CPC);
    chk("clamp_cnt", 32'(PING_COUNT), 32'd2);

    // trigger during GAP ignored
    base_e = echo_rises;
    trigger(7, 25);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (ef_cyc > rel_cyc) break;
    end
    chk("gap_echo_seen", 32'(ef_cyc > rel_cyc), 32'd1);
    @(negedge CLK);
    host_oe = 1'b1;
    repeat (30) @(negedge CLK);
    host_oe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!BUSY) break;
    end
    repeat (60) @(negedge CLK);
    chk("gap_echoes", 32'(echo_rises - base_e), 32'd1);
    chk("gap_cnt",    32'(PING_COUNT), 32'd3);

    trigger(7, 25);
    wait_done("after_gap", 1000);
    chk_ping("after_gap", 7 * CPC);
    chk("after_gap_cnt", 32'(PING_COUNT), 32'd4);

    trigger(1, 30);
    wait_done("d1", 1000);
    chk("d1_width", 32'(ef_cyc - er_cyc), 32'(2 * CPC));

    trigger(255, 30);
    wait_done("d255", 5000);
    chk_ping("d255", EXP_255);
    chk("d255_cnt", 32'(PING_COUNT), 32'd6);

    // reset 1000 cycles into ECHO
    trigger(200, 30);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (ECHO_ACTIVE) break;
    end
    chk("mid_echo_on", 32'(ECHO_ACTIVE), 32'd1);
    repeat (1000) @(negedge CLK);
    chk("mid_still_on", 32'(ECHO_ACTIVE), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_echo", 32'(ECHO_ACTIVE), 32'd0);
    chk("mid_rst_sig",  32'(sig_w), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_cnt",  32'(PING_COUNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    trigger(3, 25);
    wait_done("post_rst", 1000);
    chk_ping("post_rst", 3 * CPC);
    chk("post_rst_cnt", 32'(PING_COUNT), 32'd1);

    chk("sig_track", 32'(sig_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
